ddr3_port_sched: RTL

- Burst scheduler that shares the single DDR3 user command port between four camera write channels (wfifo side) and one display read channel (rfifo side).
- Decides which channel gets the next burst, generates its DDR3 address, and hands a burst descriptor to the burst engine that drives the DDR3 IP command/data handshake.
- Sits in the ui_clk domain between the FIFO control top (fill counts, frame pulses) and the DDR3 read/write burst engine.

---
 rtl/ddr3_sched_pkg.sv | 21 ++
 rtl/ddr3_rr_arb4.sv | 27 ++
 rtl/ddr3_port_sched.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/ddr3_sched_pkg.sv
// Shared types and constants for the DDR3 user-port burst scheduler.
package ddr3_sched_pkg;

    localparam int ADDR_W_DEF    = 28;
    localparam int CNT_W_DEF     = 11;
    localparam int LEN_W_DEF     = 8;
    localparam int BEAT_ADDR_DEF = 8;

    localparam int NUM_WR_CH = 4;
    // Channel selects 0..3 are the camera writers; the display reader sits after them.
    localparam logic [2:0] RD_CH_SEL = 3'd4;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        ISSUE,
        WAIT,
        UPDATE
    } sched_state_e;

endpackage

// File: rtl/ddr3_rr_arb4.sv
// Combinational 4-way round-robin picker: the first requester at or after ptr_i wins.
module ddr3_rr_arb4 (
    input  logic [3:0] req_i,
    input  logic [1:0] ptr_i,
    output logic [3:0] gnt_o,
    output logic       valid_o
);

    logic [1:0] idx;
    logic       found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr_i + 2'(i);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/ddr3_port_sched.sv
// Burst scheduler sharing the DDR3 user command port between four camera writers
// and one display reader; arbitrates, generates addresses and presents descriptors.
module ddr3_port_sched
    import ddr3_sched_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int LEN_W     = LEN_W_DEF,
    parameter int BEAT_ADDR = BEAT_ADDR_DEF
) (
    input  logic                          ui_clk,
    input  logic                          rst_n,
    input  logic                          init_calib_complete,
    input  logic [LEN_W-1:0]              wr_bust_len,
    input  logic [LEN_W-1:0]              rd_bust_len,
    input  logic [NUM_WR_CH*CNT_W-1:0]    wfifo_rcount,
    input  logic [CNT_W-1:0]              rfifo_wcount,
    input  logic [CNT_W-1:0]              rd_req_th,
    input  logic [CNT_W-1:0]              rd_urgent_th,
    input  logic [NUM_WR_CH*ADDR_W-1:0]   wr_base,
    input  logic [ADDR_W-1:0]             rd_base,
    input  logic [ADDR_W-1:0]             frame_span,
    input  logic [NUM_WR_CH-1:0]          wr_load_p,
    input  logic                          rd_load_p,
    output logic                          burst_req,
    input  logic                          burst_ack,
    input  logic                          burst_done,
    output logic                          burst_is_rd,
    output logic [1:0]                    burst_ch,
    output logic [ADDR_W-1:0]             burst_addr,
    output logic [LEN_W-1:0]              burst_len,
    output logic                          busy
);

    localparam int NCH   = NUM_WR_CH + 1;
    localparam int CMP_W = (CNT_W > LEN_W) ? CNT_W : LEN_W;

    sched_state_e state_q;
    logic [1:0]        rr_q;
    logic [2:0]        sel_q;
    logic [ADDR_W-1:0] off_q [NCH];
    logic [NCH-1:0]    pend_q;
    logic              burst_req_q, burst_is_rd_q, busy_q;
    logic [1:0]        burst_ch_q;
    logic [ADDR_W-1:0] burst_addr_q;
    logic [LEN_W-1:0]  burst_len_q;

    logic [ADDR_W-1:0] base_a [NCH];
    logic [NCH-1:0]    load_a;
    logic [NUM_WR_CH-1:0] wr_elig, wr_gnt;
    logic              wr_any, rd_elig, rd_urg, pick_rd, any_elig;
    logic [2:0]        grant_sel;
    logic [NCH-1:0]    in_use;
    logic [ADDR_W-1:0] step, upd_off, wrapped_off;

    // Channels 0..3 are writers, index RD_CH_SEL is the reader, so all
    // per-channel state can live in one array.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_WR_CH; gi++) begin : g_wr
            assign base_a[gi]  = wr_base[gi*ADDR_W +: ADDR_W];
            assign wr_elig[gi] = (CMP_W'(wfifo_rcount[gi*CNT_W +: CNT_W]) >= CMP_W'(wr_bust_len))
                                 && (wr_bust_len != '0);
        end
    endgenerate
    assign base_a[NUM_WR_CH] = rd_base;
    assign load_a            = {rd_load_p, wr_load_p};

    assign rd_elig  = (rfifo_wcount < rd_req_th) && (rd_bust_len != '0);
    assign rd_urg   = (rfifo_wcount < rd_urgent_th) && (rd_bust_len != '0);

    ddr3_rr_arb4 u_rr_arb (
        .req_i   (wr_elig),
        .ptr_i   (rr_q),
        .gnt_o   (wr_gnt),
        .valid_o (wr_any)
    );

    assign pick_rd  = rd_urg || !wr_any;
    assign any_elig = rd_urg || wr_any || rd_elig;

    always_comb begin
        grant_sel = RD_CH_SEL;
        if (!pick_rd) begin
            for (int i = 0; i < NUM_WR_CH; i++) begin
                if (wr_gnt[i]) grant_sel = 3'(i);
            end
        end
    end

    // A channel counts as granted from the ARB decision until its UPDATE; frame
    // pulses in that window are deferred so the in-flight address stays valid.
    always_comb begin
        in_use = '0;
        for (int c = 0; c < NCH; c++) begin
            if ((state_q == ISSUE || state_q == WAIT) && sel_q == 3'(c)) in_use[c] = 1'b1;
            if (state_q == ARB && init_calib_complete && any_elig && grant_sel == 3'(c))
                in_use[c] = 1'b1;
        end
    end

    assign step        = ADDR_W'(burst_len_q) * ADDR_W'(BEAT_ADDR);
    assign upd_off     = off_q[sel_q] + step;
    assign wrapped_off = (upd_off >= frame_span) ? '0 : upd_off;

    always_ff @(posedge ui_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rr_q          <= '0;
            sel_q         <= '0;
            pend_q        <= '0;
            burst_req_q   <= 1'b0;
            burst_is_rd_q <= 1'b0;
            burst_ch_q    <= '0;
            burst_addr_q  <= '0;
            burst_len_q   <= '0;
            busy_q        <= 1'b0;
            for (int c = 0; c < NCH; c++) off_q[c] <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (state_q == UPDATE && sel_q == 3'(c)) begin
                    off_q[c]  <= (pend_q[c] || load_a[c]) ? '0 : wrapped_off;
                    pend_q[c] <= 1'b0;
                end else if (load_a[c]) begin
                    if (in_use[c]) pend_q[c] <= 1'b1;
                    else           off_q[c]  <= '0;
                end
            end

            case (state_q)
                IDLE: begin
                    if (init_calib_complete) begin
                        state_q <= ARB;
                        busy_q  <= 1'b1;
                    end
                end
                ARB: begin
                    if (!init_calib_complete) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (any_elig) begin
                        sel_q         <= grant_sel;
                        burst_is_rd_q <= pick_rd;
                        burst_ch_q    <= pick_rd ? 2'd0 : grant_sel[1:0];
                        burst_addr_q  <= base_a[grant_sel] + off_q[grant_sel];
                        burst_len_q   <= pick_rd ? rd_bust_len : wr_bust_len;
                        burst_req_q   <= 1'b1;
                        state_q       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (burst_ack) begin
                        burst_req_q <= 1'b0;
                        state_q     <= WAIT;
                    end
                end
                WAIT: begin
                    if (burst_done) state_q <= UPDATE;
                end
                UPDATE: begin
                    if (!burst_is_rd_q) rr_q <= burst_ch_q + 2'd1;
                    if (init_calib_complete) begin
                        state_q <= ARB;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    burst_req_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign burst_req   = burst_req_q;
    assign burst_is_rd = burst_is_rd_q;
    assign burst_ch    = burst_ch_q;
    assign burst_addr  = burst_addr_q;
    assign burst_len   = burst_len_q;
    assign busy        = busy_q;

endmodule
